// File: rtl/lcd_serial_rx.sv
// lcd_serial_rx: 8N1 UART receiver feeding a 2x16 character LCD command parser
module lcd_serial_rx #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       SYSCLK,
  input  logic       SYSRESET,
  input  logic       RXD,
  output logic       RX_VALID,
  output logic [7:0] RX_DATA,
  output logic       FRAME_ERR,
  output logic       WR_EN,
  output logic [4:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       CLR,
  output logic [4:0] CURSOR,
  output logic [4:0] BACKLIGHT
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  typedef enum logic [1:0] {NORMAL, CMD, BL} p_state_t;
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  logic rx_s1, rx_s2, rx_prev;
  rx_state_t rx_st, rx_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, data_n;
  logic valid_n, ferr_n, tick;
  p_state_t ps, ps_n;
  logic we_n, clr_n, printable;
  logic [4:0] addr_n, cur_n, bl_n;
  logic [7:0] wd_n;
  assign tick = cnt == 16'd0;
  assign printable = RX_DATA >= 8'h20 && RX_DATA <= 8'h7E && RX_DATA != 8'h7C;
  // two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) {rx_s1, rx_s2, rx_prev} <= 3'b111;
    else {rx_s1, rx_s2, rx_prev} <= {RXD, rx_s1, rx_s2};
  end
  // receiver next-state: half-bit start qualification, then mid-bit sampling
  always_comb begin
    rx_n = rx_st;
    cnt_n = cnt - 16'd1;
    idx_n = idx;
    sh_n = sh;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    data_n = RX_DATA;
    case (rx_st)
      IDLE: if (rx_prev && !rx_s2) begin
        rx_n = START;
        cnt_n = HALF;
      end
      START: if (tick) begin
        rx_n = rx_s2 ? IDLE : DATA;
        cnt_n = FULL;
        idx_n = 3'd0;
      end
      DATA: if (tick) begin
        sh_n = {rx_s2, sh[7:1]};
        idx_n = idx + 3'd1;
        cnt_n = FULL;
        rx_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        rx_n = rx_s2 ? IDLE : BREAK;
        valid_n = rx_s2;
        ferr_n = !rx_s2;
        data_n = rx_s2 ? sh : RX_DATA;
      end
      BREAK: rx_n = rx_s2 ? IDLE : BREAK;
      default: rx_n = IDLE;
    endcase
  end
  // receiver state and registered result pulses
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      rx_st <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      RX_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      RX_DATA <= '0;
    end else begin
      rx_st <= rx_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      RX_VALID <= valid_n;
      FRAME_ERR <= ferr_n;
      RX_DATA <= data_n;
    end
  end
  // parser next-state: printable bytes write at the cursor, 0xFE/0x7C prefix one argument byte
  always_comb begin
    ps_n = ps;
    we_n = 1'b0;
    clr_n = 1'b0;
    addr_n = WR_ADDR;
    wd_n = WR_DATA;
    cur_n = CURSOR;
    bl_n = BACKLIGHT;
    if (RX_VALID) begin
      case (ps)
        NORMAL: begin
          ps_n = RX_DATA == 8'hFE ? CMD : RX_DATA == 8'h7C ? BL : NORMAL;
          if (printable) begin
            we_n = 1'b1;
            addr_n = CURSOR;
            wd_n = RX_DATA;
            cur_n = CURSOR + 5'd1;
          end
        end
        CMD: begin
          ps_n = NORMAL;
          clr_n = RX_DATA == 8'h01;
          cur_n = RX_DATA == 8'h01 ? 5'd0 :
                  (RX_DATA[7] && RX_DATA[5:4] == 2'b00) ? {RX_DATA[6], RX_DATA[3:0]} : CURSOR;
        end
        BL: begin
          ps_n = NORMAL;
          bl_n = (RX_DATA >= 8'd128 && RX_DATA <= 8'd157) ? 5'(RX_DATA - 8'd128) : BACKLIGHT;
        end
        default: ps_n = NORMAL;
      endcase
    end
  end
  // parser registers; write address/data hold between strobes
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      ps <= NORMAL;
      WR_EN <= 1'b0;
      CLR <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= '0;
      CURSOR <= '0;
      BACKLIGHT <= 5'd29;
    end else begin
      ps <= ps_n;
      WR_EN <= we_n;
      CLR <= clr_n;
      WR_ADDR <= addr_n;
      WR_DATA <= wd_n;
      CURSOR <= cur_n;
      BACKLIGHT <= bl_n;
    end
  end
endmodule

// File: doc/lcd_serial_rx.md
LCD_SERIAL_RX -- requirements
Module: lcd_serial_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1042, SYSCLK cycles per UART bit (10 MHz / 9600 baud); legal range 8..65535.
REQ-002 SYSCLK  input  1  sole clock; all logic on rising edge.
REQ-003 SYSRESET  input  1  reset, synchronous, active-high.
REQ-004 RXD  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-005 RX_VALID  output  1  one-cycle pulse: RX_DATA holds a good byte.
REQ-006 RX_DATA  output  8  last good received byte.
REQ-007 FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 WR_EN  output  1  one-cycle character-write strobe to the display buffer.
REQ-009 WR_ADDR  output  5  buffer address: bit4 = line (0 top, 1 bottom), bits3:0 = column.
REQ-010 WR_DATA  output  8  character code to write.
REQ-011 CLR  output  1  one-cycle clear-display pulse.
REQ-012 CURSOR  output  5  current cursor address.
REQ-013 BACKLIGHT  output  5  backlight level, 0..29.

Function -- UART receiver
REQ-014 RXD SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-015 States SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE -> START on a synchronized high-to-low transition; the bit counter loads CLKS_PER_BIT/2.
REQ-017 START: at the half-bit point, line low -> DATA; line high -> IDLE (glitch rejected, no output).
REQ-018 DATA: sample every CLKS_PER_BIT cycles; 8 bits, shift LSB first -> STOP.
REQ-019 STOP: sample after CLKS_PER_BIT cycles. High: RX_DATA updated and RX_VALID pulsed on the next cycle, then -> IDLE. Low: FRAME_ERR pulsed, RX_DATA unchanged, -> BREAK.
REQ-020 BREAK SHALL wait for a synchronized high before returning to IDLE; a held-low line SHALL never produce a second FRAME_ERR.
REQ-021 A new start edge SHALL be accepted from the cycle after returning to IDLE; no byte is lost at back-to-back 8N1 traffic.

Function -- command parser
REQ-022 The parser SHALL act only on RX_VALID; its outputs are registered one cycle after RX_VALID.
REQ-023 Parser states SHALL be NORMAL, CMD, BL.
REQ-024 NORMAL, byte 0x20..0x7E: WR_EN=1, WR_ADDR=CURSOR, WR_DATA=byte; CURSOR increments, with 31 wrapping to 0.
REQ-025 NORMAL, byte 0xFE -> CMD; byte 0x7C -> BL; any other byte is ignored.
REQ-026 CMD, byte 0x01: pulse CLR; CURSOR=0.
REQ-027 CMD, byte[7]=1 and byte[5:4]=00: CURSOR={byte[6],byte[3:0]} (0x80-0x8F top line, 0xC0-0xCF bottom line).
REQ-028 CMD, any other byte is ignored; CMD always returns to NORMAL after one byte.
REQ-029 BL, byte 128..157: BACKLIGHT=byte-128; any other byte is ignored; BL always returns to NORMAL.
REQ-030 WR_EN and CLR SHALL never assert in the same cycle; WR_ADDR and WR_DATA SHALL hold their values when WR_EN=0.
REQ-031 A framing-error byte SHALL NOT advance the parser state.

Reset
REQ-032 SYSRESET SHALL force receiver IDLE, parser NORMAL, RX_VALID/FRAME_ERR/WR_EN/CLR=0, RX_DATA=0x00, WR_ADDR=0, WR_DATA=0x00, CURSOR=0, BACKLIGHT=29, synchronizer flops=1.
REQ-033 Reset asserted mid-byte SHALL discard the partial byte; after release, the next start edge SHALL be received correctly.

Verification (CLKS_PER_BIT=16)
REQ-034 Send 0x41 -> RX_VALID with RX_DATA=0x41; next cycle WR_EN, WR_ADDR=0, WR_DATA=0x41; CURSOR=1.
REQ-035 Send 32 x 0x30, then 0x31 -> 0x31 written at WR_ADDR=0; CURSOR=1 (wrap).
REQ-036 Send 0xFE,0xC5, then 'X' -> 'X' written at WR_ADDR=0x15; send 0xFE,0x01 -> CLR pulse, CURSOR=0, no WR_EN.
REQ-037 Send 0x7C,0x8A -> BACKLIGHT=10; send 0x7C,0x20 -> BACKLIGHT stays 10, no write of 0x20.
REQ-038 Send a byte with a low stop bit, then hold RXD low for 40 bit times -> exactly one FRAME_ERR and no RX_VALID; after RXD returns high, 0x42 is received correctly.
REQ-039 Apply a low pulse of 4 cycles on idle RXD -> no RX_VALID or FRAME_ERR; assert SYSRESET in mid-DATA -> all outputs at reset values, and the next byte is received correctly.
